// File: rtl/mips_mem_access_unit_if.sv
// rtl/mips_mem_access_unit_if.sv - core request/response and Avalon master signals of the load/store unit
interface mips_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output address, read, write, writedata, byteenable
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mips_mem_access_unit.sv
// rtl/mips_mem_access_unit.sv - one-at-a-time load/store unit driving an Avalon master with lane steering
module mips_mem_access_unit (
  input logic                     clk,
  input logic                     reset_n,
  mips_mem_access_unit_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d;

  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wlanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    req_err = (bus.req_size == 2'b11)
            | ((bus.req_size == 2'b01) & bus.req_addr[0])
            | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));

    case (bus.req_size)
      2'b00: begin
        req_be     = 4'b0001 << bus.req_addr[1:0];
        req_wlanes = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        req_be     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        req_wlanes = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        req_be     = 4'b1111;
        req_wlanes = bus.req_wdata;
      end
    endcase

    case (lane_q)
      2'b00:   ld_byte = bus.readdata[7:0];
      2'b01:   ld_byte = bus.readdata[15:8];
      2'b10:   ld_byte = bus.readdata[23:16];
      default: ld_byte = bus.readdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.readdata[31:16] : bus.readdata[15:0];

    case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_mis_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_write;
          size_d     = bus.req_size;
          signed_d   = bus.req_signed;
          lane_d     = bus.req_addr[1:0];
          if (req_err) begin
            // Rejected requests skip the bus entirely and answer next cycle.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
          end else begin
            state_d   = BUS;
            read_d    = ~bus.req_write;
            write_d   = bus.req_write;
            address_d = {bus.req_addr[31:2], 2'b00};
            be_d      = req_be;
            wdata_d   = req_wlanes;
          end
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          state_d      = RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          address_d    = 32'd0;
          be_d         = 4'd0;
          wdata_d      = 32'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = is_store_q ? 32'd0 : ld_data;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.read            = read_q;
  assign bus.write           = write_q;
  assign bus.address         = address_q;
  assign bus.writedata       = wdata_q;
  assign bus.byteenable      = be_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;
endmodule

// File: tb/tb_mips_mem_access_unit.sv
// tb/tb_mips_mem_access_unit.sv - scoreboard bench with a random Avalon slave and a behavioural load/store model
module tb_mips_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mips_mem_access_unit_if ifc ();

  mips_mem_access_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          acc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
    int          w;
  } bus_t;

  typedef struct {
    int          w;
    logic [31:0] rd;
  } slv_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  slv_t  slv_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference behaviour expressed as plain arithmetic on the byte address.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output logic err, output logic [3:0] be,
                                output logic [31:0] wdo, output logic [31:0] res);
    logic [31:0] k;
    logic [31:0] fld;
    k   = a % 4;
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && k != 0);
    be  = 4'hF;
    wdo = wd;
    fld = rd;
    if (sz == 2'd0) begin
      be  = 4'(32'd1 << k);
      wdo = {24'd0, wd[7:0]} * 32'h01010101;
      fld = (rd >> (8 * k)) & 32'hFF;
      if (sg && fld >= 32'd128) fld = fld - 32'd256;
    end else if (sz == 2'd1) begin
      be  = (k >= 2) ? 4'hC : 4'h3;
      wdo = {16'd0, wd[15:0]} * 32'h00010001;
      fld = (rd >> (16 * (k / 2))) & 32'hFFFF;
      if (sg && fld >= 32'd32768) fld = fld - 32'd65536;
    end
    res = (wr || err) ? 32'd0 : fld;
  endfunction

  // Called just after a rising edge; returns just after the edge that follows the accept.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int w,
                       input bit hold, output int acc);
    logic        err;
    logic [3:0]  be;
    logic [31:0] wdo, res;
    model(wr, sz, sg, a, wd, rd, err, be, wdo, res);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = wr;
    ifc.req_size   = sz;
    ifc.req_signed = sg;
    ifc.req_addr   = a;
    ifc.req_wdata  = wd;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.req_ready) begin
        acc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      resp_q.push_back('{res, err, acc, err ? 1 : w + 2});
      if (!err) begin
        bus_q.push_back('{a & 32'hFFFF_FFFC, be, wdo, wr, w});
        slv_q.push_back('{w, rd});
      end
    end
    @(posedge clk);
    #1;
    if (!hold) ifc.req_valid = 1'b0;
  endtask

  // Avalon slave: stalls for the per-transaction wait count, random noise otherwise.
  initial begin
    slv_t cur;
    bit   s_prev;
    int   cnt;
    logic stb;
    cur    = '{0, 32'd0};
    s_prev = 1'b0;
    cnt    = 0;
    ifc.waitrequest = 1'b0;
    ifc.readdata    = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      stb = ifc.read | ifc.write;
      if (!reset_n) stb = 1'b0;
      if (stb && !s_prev) begin
        if (slv_q.size() > 0) cur = slv_q.pop_front();
        cnt = 0;
      end
      if (stb) begin
        ifc.waitrequest = (cnt < cur.w);
        ifc.readdata    = cur.rd;
        cnt++;
      end else begin
        ifc.waitrequest = 1'($urandom_range(0, 1));
        ifc.readdata    = $urandom;
      end
      s_prev = stb;
    end
  end

  // Monitor: bus-phase checks and response scoreboard.
  initial begin
    bus_t  cb;
    resp_t cr;
    bit    m_prev;
    int    m_len;
    logic  stb;
    cb     = '{32'd0, 4'd0, 32'd0, 1'b0, 0};
    m_prev = 1'b0;
    m_len  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_prev = 1'b0;
        m_len  = 0;
      end else begin
        chk("strobe_exclusive", 32'(ifc.read & ifc.write), 32'd0);
        stb = ifc.read | ifc.write;
        if (stb && !m_prev) begin
          m_len = 0;
          if (bus_q.size() == 0) chk("unexpected_bus_cycle", 32'd1, 32'd0);
          else cb = bus_q.pop_front();
        end
        if (stb) begin
          m_len++;
          chk("bus_address", ifc.address, cb.addr);
          chk("bus_byteenable", 32'(ifc.byteenable), 32'(cb.be));
          chk("bus_kind_write", 32'(ifc.write), 32'(cb.wr));
          if (cb.wr) chk("bus_writedata", ifc.writedata, cb.wdata);
        end
        if (!stb && m_prev) chk("strobe_len", 32'(m_len), 32'(cb.w + 1));
        m_prev = stb;
        if (ifc.resp_valid) begin
          if (resp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            cr = resp_q.pop_front();
            chk("resp_rdata", ifc.resp_rdata, cr.rdata);
            chk("resp_misaligned", 32'(ifc.resp_misaligned), 32'(cr.mis));
            chk("resp_latency", 32'(cyc - cr.acc), 32'(cr.lat));
            chk("ready_in_resp", 32'(ifc.req_ready), 32'd0);
          end
        end else begin
          chk("resp_idle_zero", {ifc.resp_rdata[31:1], ifc.resp_rdata[0] | ifc.resp_misaligned}, 32'd0);
        end
      end
    end
  end

  initial begin
    int          acc;
    int          accs[$];
    logic [1:0]  sz;
    logic [31:0] a;
    ifc.req_valid  = 1'b0;
    ifc.req_write  = 1'b0;
    ifc.req_size   = 2'b00;
    ifc.req_signed = 1'b0;
    ifc.req_addr   = 32'd0;
    ifc.req_wdata  = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_read", 32'(ifc.read), 32'd0);
    chk("rst_write", 32'(ifc.write), 32'd0);
    chk("rst_address", ifc.address, 32'd0);
    chk("rst_writedata", ifc.writedata, 32'd0);
    chk("rst_byteenable", 32'(ifc.byteenable), 32'd0);
    chk("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;

    issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'd0, 32'h80FFEE11, 0, 1'b0, acc);
    issue(1'b0, 2'd1, 1'b0, 32'h2002, 32'd0, 32'hBEEF1234, 3, 1'b0, acc);
    issue(1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'd0, 0, 1'b0, acc);
    issue(1'b0, 2'd2, 1'b0, 32'h4002, 32'd0, 32'd0, 0, 1'b0, acc);
    issue(1'b0, 2'd3, 1'b0, 32'h4000, 32'd0, 32'd0, 0, 1'b0, acc);
    repeat (4) begin @(posedge clk); #1; end

    issue(1'b0, 2'd2, 1'b0, 32'h500, 32'd0, 32'h12345678, 20, 1'b0, acc);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_read_drop", 32'(ifc.read), 32'd0);
    chk("abort_resp_valid", 32'(ifc.resp_valid), 32'd0);
    if (resp_q.size() > 0) void'(resp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(ifc.req_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 32'hCAFEF00D, 1, 1'b0, acc);
    repeat (4) begin @(posedge clk); #1; end

    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, $urandom, 0, 1'b1, acc);
      accs.push_back(acc);
    end
    ifc.req_valid = 1'b0;
    for (int i = 1; i < accs.size(); i++) chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd3);
    repeat (3) begin @(posedge clk); #1; end

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~(32'd1 << sz);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
            $urandom_range(0, 3), 1'b0, acc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    for (int i = 0; i < 300 && resp_q.size() > 0; i++) @(posedge clk);
    chk("drain_pending", 32'(resp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_access_unit.md
# mips_mem_access_unit

Load/store access unit between the MIPS CPU execute stage and the Avalon memory-mapped bus. It accepts one data-memory request at a time from the core and runs the Avalon master handshake, including wait states. It generates byte-lane enables and lane-replicated write data, and returns sign- or zero-extended load data. Misaligned or illegal-size requests are rejected without a bus cycle.

## Interface
- No parameters. The address and data width is fixed at 32.
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  qualifies resp_valid: request was rejected
- address  out  32  Avalon word address {addr[31:2],2'b00}
- read / write  out  1 each  Avalon strobes; never both high
- waitrequest  in  1  slave stall
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon lane enables
- readdata  in  32  Avalon read data

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and check it.
  - Error cases: size 11; halfword with addr[0]=1; word with addr[1:0]≠0.
  - On error, go to RESP with the misaligned flag set and no bus activity. Otherwise go to BUS.
- BUS:
  - read=!req_write and write=req_write, registered.
  - address, byteenable and writedata are stable for the whole state.
  - Stay in BUS while waitrequest=1.
  - When waitrequest=0: capture readdata if this is a load, deassert the strobe, and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. A req_valid in RESP is not accepted.
- Little-endian lane mapping, with k=addr[1:0]:
  - Byte: byteenable=1<<k; writedata={4{wdata[7:0]}}.
  - Half: byteenable=0011 if addr[1]=0, else 1100; writedata={2{wdata[15:0]}}.
  - Word: byteenable=1111; writedata=wdata.
- Load extraction:
  - Byte: readdata[8k+7:8k].
  - Half: readdata[16·addr[1]+15 : 16·addr[1]].
  - The selected field is extended to 32 bits per req_signed. req_signed is ignored for word loads.

## Timing
- Reset (asynchronous, immediate): state=IDLE; read=write=0; address=writedata=0; byteenable=0; resp_valid=0; resp_rdata=0; resp_misaligned=0; req_ready=1 after reset deasserts.
- Reset mid-BUS: strobes drop at once and no response is issued. The core must reissue the request.
- Accept in cycle N. The strobe is high from N+1. If waitrequest=0 in cycle N+1+W, resp_valid is high in cycle N+2+W. With zero wait states, latency is 2 cycles.
- Error path: accept in N, resp_valid with resp_misaligned=1 in N+1, and read/write stay 0 throughout.
- Back-to-back throughput: the next accept is no earlier than the cycle after RESP, i.e. at most one request per 3 cycles.
- resp_rdata and resp_misaligned are valid only while resp_valid=1. Outside that cycle they hold 0.
- waitrequest is sampled only in BUS. Changes of req_* while the unit is not in IDLE are ignored.

## Test plan
- Signed byte load:
  - Stimulus: addr 0x1003, readdata 0x80FFEE11, waitrequest 0.
  - Required: address 0x1000, byteenable 1000, read pulse of 1 cycle, resp_rdata 0xFFFFFF80 two cycles after accept.
- Unsigned halfword load:
  - Stimulus: addr 0x2002, readdata 0xBEEF1234, waitrequest high for 3 cycles.
  - Required: read held 4 cycles with stable address 0x2000, byteenable 1100; resp_rdata 0x0000BEEF; latency 5 cycles.
- Byte store:
  - Stimulus: addr 0x3001, wdata 0x000000A5.
  - Required: write=1, writedata 0xA5A5A5A5, byteenable 0010, resp_rdata 0, resp_misaligned 0.
- Misaligned word load at 0x4002, and size 11 at 0x4000:
  - Required: no read or write strobe; resp_valid with resp_misaligned=1 the cycle after accept.
- Reset mid-transaction:
  - Stimulus: assert reset_n low while in BUS with waitrequest=1.
  - Required: read=0 in the same cycle, no resp_valid, req_ready=1 after release; a fresh word load at 0x0 then completes normally.
- Back-to-back requests:
  - Stimulus: req_valid held high continuously.
  - Required: accepts spaced exactly 3 cycles apart with zero wait states; read and write never asserted together.
